// File: rtl/output_sram_bank_array.sv
// output_sram_bank_array: banked output-buffer SRAM controller, NUM_BANKS rows x DATA_W/SRAM_W column macros.
// Latency: 2 cycles from request to d_ready/w_done/addr_err; 3 cycles with OUTPUT_SRAM_RDATA_REG_EN defined.
// Backpressure: writes always accepted; a read colliding with a write sees r_stall and is held by the requester.

// sram_behav: single-port behavioural SRAM with macro-compatible pins (active-low csb0/web0).
// Latency: 1 cycle read, dout0 updates on the edge that samples the read.
// Backpressure: none; one access per cycle.
module sram_behav #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk0,
  input  logic              csb0,
  input  logic              web0,
  input  logic [AW-1:0]     addr0,
  input  logic [DATA_W-1:0] din0,
  output logic [DATA_W-1:0] dout0
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on selected write cycles, register read data on selected read cycles
  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) mem[addr0] <= din0;
    if (!csb0 && web0)  dout0 <= mem[addr0];
  end

endmodule

// sram_32_2048_scn4m_subm: simulation view of the 32x2048 hard macro; the library view replaces it in implementation.
// Latency: 1 cycle read.
// Backpressure: none; one access per cycle.
module sram_32_2048_scn4m_subm (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [10:0] addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0
);

  sram_behav #(.DATA_W(32), .DEPTH(2048), .AW(11)) u_model (
    .clk0  (clk0),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0)
  );

endmodule

// output_sram_bank_array: banked output buffer between the accelerator output writer and the readback/DMA path.
// Latency: 2 cycles (3 when OUTPUT_SRAM_RDATA_REG_EN is defined: r_d registered and held between reads).
// Backpressure: r_stall = w_en & r_en; the write wins and the read must be held; out-of-range requests pulse addr_err.
module output_sram_bank_array #(
  parameter int DATA_W     = 64,
  parameter int SRAM_W     = 32,
  parameter int BANK_DEPTH = 2048,
  parameter int NUM_BANKS  = 6,
  parameter int ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_d,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_stall,
  output logic [DATA_W-1:0] r_d,
  output logic              d_ready,
  output logic              w_done,
  output logic              addr_err
);

  localparam int ROW_AW  = $clog2(BANK_DEPTH);
  localparam int BANK_AW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int COLS    = DATA_W / SRAM_W;
  localparam logic [BANK_AW:0] BANK_LIMIT = (BANK_AW+1)'(NUM_BANKS);

  typedef struct packed {
    logic               vld;
    logic               is_rd;
    logic               err;
    logic [BANK_AW-1:0] bank;
  } stage_t;

  logic              rd_acc;
  logic              req_vld;
  logic [ADDR_W-1:0] req_addr;
  logic [ROW_AW-1:0] req_row;
  logic [BANK_AW-1:0] req_bank;
  logic              req_err;
  logic              unused_addr_bits;

  stage_t                s1_q;
  stage_t                s2_q;
  logic [NUM_BANKS-1:0]  bank_csb;
  logic [NUM_BANKS-1:0]  bank_web;
  logic [NUM_BANKS-1:0]  sel_dec;
  logic [ROW_AW-1:0]     row_q;
  logic [DATA_W-1:0]     wd_q;
  logic [SRAM_W-1:0]     col_dout [NUM_BANKS][COLS];
  logic [DATA_W-1:0]     rd_mux;
  logic                  rd_fin;
  logic                  wr_fin;
  logic                  err_fin;

  // A write always wins the single port; the colliding read is told to hold
  assign r_stall  = w_en & r_en;
  assign rd_acc   = r_en & ~w_en;
  assign req_vld  = w_en | r_en;
  assign req_addr = w_en ? w_addr : r_addr;
  assign req_row  = req_addr[ROW_AW-1:0];
  assign req_bank = req_addr[ROW_AW +: BANK_AW];
  assign req_err  = {1'b0, req_bank} >= BANK_LIMIT;

  // Address bits above the bank field are deliberately ignored
  assign unused_addr_bits = ^req_addr;

  // One-hot bank select for in-range accepted requests
  always_comb begin
    sel_dec = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_dec[b] = req_vld & ~req_err & (req_bank == BANK_AW'(b));
    end
  end

  // E0: register macro strobes, row, write data and the stage-1 tag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_csb <= '1;
      bank_web <= '1;
      row_q    <= '0;
      wd_q     <= '0;
      s1_q     <= '0;
    end else begin
      bank_csb   <= ~sel_dec;
      bank_web   <= ~(sel_dec & {NUM_BANKS{w_en}});
      row_q      <= req_row;
      wd_q       <= w_d;
      s1_q.vld   <= req_vld;
      s1_q.is_rd <= rd_acc;
      s1_q.err   <= req_err;
      s1_q.bank  <= req_bank;
    end
  end

  // E1: the macros perform the access while the tag moves to stage 2
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) s2_q <= '0;
    else        s2_q <= s1_q;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (SRAM_W == 32 && BANK_DEPTH == 2048) begin : g_macro
        sram_32_2048_scn4m_subm u_sram (
          .clk0  (clock),
          .csb0  (bank_csb[b]),
          .web0  (bank_web[b]),
          .addr0 (row_q),
          .din0  (wd_q[c*SRAM_W +: SRAM_W]),
          .dout0 (col_dout[b][c])
        );
      end else begin : g_behav
        sram_behav #(.DATA_W(SRAM_W), .DEPTH(BANK_DEPTH), .AW(ROW_AW)) u_sram (
          .clk0  (clock),
          .csb0  (bank_csb[b]),
          .web0  (bank_web[b]),
          .addr0 (row_q),
          .din0  (wd_q[c*SRAM_W +: SRAM_W]),
          .dout0 (col_dout[b][c])
        );
      end
    end
  end

  // C2: assemble the stage-2 bank's column outputs into one word
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (s2_q.bank == BANK_AW'(b)) begin
        for (int c = 0; c < COLS; c++) begin
          rd_mux[c*SRAM_W +: SRAM_W] = col_dout[b][c];
        end
      end
    end
  end

  assign rd_fin  = s2_q.vld &  s2_q.is_rd & ~s2_q.err;
  assign wr_fin  = s2_q.vld & ~s2_q.is_rd & ~s2_q.err;
  assign err_fin = s2_q.vld &  s2_q.err;

`ifdef OUTPUT_SRAM_RDATA_REG_EN
  // C3: register completions; r_d captures only completed reads and holds in between
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_ready  <= 1'b0;
      w_done   <= 1'b0;
      addr_err <= 1'b0;
      r_d      <= '0;
    end else begin
      d_ready  <= rd_fin;
      w_done   <= wr_fin;
      addr_err <= err_fin;
      if (rd_fin) r_d <= rd_mux;
    end
  end
`else
  assign d_ready  = rd_fin;
  assign w_done   = wr_fin;
  assign addr_err = err_fin;
  assign r_d      = rd_mux;
`endif

endmodule
